// File: rtl/syzygy_adc_pkg.sv
// Purpose : shared types and helpers for the SYZYGY ADC capture block.
// Contents: capture FSM state enum, sample/word widths, offset-binary to
//           two's-complement conversion.
package syzygy_adc_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } adc_cap_state_t;

  // raw holds a width-bit offset-binary sample, zero-extended to SAMPLE_W.
  // Inverting the MSB gives two's complement; that bit is then copied
  // into every bit above it to sign-extend to SAMPLE_W.
  function automatic logic [SAMPLE_W-1:0] offset_to_twos(
    input logic [SAMPLE_W-1:0] raw,
    input int                  width
  );
    logic [SAMPLE_W-1:0] res;
    logic                sign;
    res  = raw;
    sign = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (i == width - 1) sign = ~raw[i];
    end
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (i >= width - 1) res[i] = sign;
    end
    return res;
  endfunction

endpackage

// File: rtl/syzygy_adc_pack.sv
// Purpose : pairs converted samples into 32-bit words and holds them in a
//           single-entry valid/ready output register.
// Latency : word visible one cycle after its odd sample is presented.
// Backpressure: a word arriving while the register is stalled is dropped,
//           overflow is set, and a dropped final word moves tlast onto the
//           pending word.
// Ports   : cap_vld_i/cap_odd_i/cap_last_i/sample_i from the capture FSM,
//           clear_ovf_i on accepted start, m_t* stream, overflow_o flag.
module syzygy_adc_pack
  import syzygy_adc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_ovf_i,
  input  logic                cap_vld_i,
  input  logic                cap_odd_i,
  input  logic                cap_last_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                m_tready_i,
  output logic [WORD_W-1:0]   m_tdata_o,
  output logic                m_tvalid_o,
  output logic                m_tlast_o,
  output logic                overflow_o
);

  logic [SAMPLE_W-1:0] even_q, even_d;
  logic [WORD_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                ovf_q, ovf_d;
  logic                stalled;

  always_comb begin
    even_d   = even_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    ovf_d    = ovf_q;
    stalled  = tvalid_q & ~m_tready_i;

    if (clear_ovf_i) ovf_d = 1'b0;

    if (cap_vld_i && !cap_odd_i) even_d = sample_i;

    if (cap_vld_i && cap_odd_i) begin
      if (stalled) begin
        // Drop the new word; keep the pending one stable.
        ovf_d = 1'b1;
        if (cap_last_i) tlast_d = 1'b1;
      end else begin
        // Covers both an empty register and accept-and-reload.
        tdata_d  = {sample_i, even_q};
        tvalid_d = 1'b1;
        tlast_d  = cap_last_i;
      end
    end else if (tvalid_q && m_tready_i) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      even_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      even_q   <= even_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      ovf_q    <= ovf_d;
    end
  end

  assign m_tdata_o  = tdata_q;
  assign m_tvalid_o = tvalid_q;
  assign m_tlast_o  = tlast_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/syzygy_adc_capture.sv
// Purpose : on start, flushes the ADC pipeline then captures pair_count
//           sample pairs, converts them to two's complement and streams them.
// Latency : first m_tvalid SETTLE_CYCLES+3 cycles after the start cycle.
// Backpressure: single output register; stalled words are dropped and
//           flagged on the sticky overflow output.
// Ports   : clk/rst_n, adc_data, start/pair_count, busy/done/overflow,
//           m_tdata/m_tvalid/m_tready/m_tlast.
// Option  : SYZYGY_ADC_TEST_PATTERN_EN adds test_mode, which replaces the
//           ADC data with a ramp restarting at 0 on every accepted start.
module syzygy_adc_capture
  import syzygy_adc_pkg::*;
#(
  parameter int DATA_W        = 12,
  parameter int SETTLE_CYCLES = 8,
  parameter int COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  adc_data,
`ifdef SYZYGY_ADC_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  input  logic               start,
  input  logic [COUNT_W-1:0] pair_count,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [WORD_W-1:0]  m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  adc_cap_state_t      state_q;
  logic [DATA_W-1:0]   adc_q;
  logic [DATA_W-1:0]   src;
  logic [SET_W-1:0]    settle_q;
  logic [COUNT_W-1:0]  left_q;
  logic                odd_q;
  logic                busy_q;
  logic                done_q;
  logic                start_ok;
  logic                cap_vld;
  logic                cap_last;
  logic [SAMPLE_W-1:0] sample;

  // Input register deliberately has no reset.
  always_ff @(posedge clk) begin
    adc_q <= adc_data;
  end

  assign start_ok = start && (state_q == IDLE);

`ifdef SYZYGY_ADC_TEST_PATTERN_EN
  logic [DATA_W-1:0] ramp_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                 ramp_q <= '0;
    else if (start_ok)          ramp_q <= '0;
    else if (state_q == CAPTURE) ramp_q <= ramp_q + DATA_W'(1);
  end
  assign src = test_mode ? ramp_q : adc_q;
`else
  assign src = adc_q;
`endif

  assign sample   = offset_to_twos(SAMPLE_W'(src), DATA_W);
  assign cap_vld  = (state_q == CAPTURE);
  // left_q counts pairs still to finish, so 2^COUNT_W-1 needs no extra bit.
  assign cap_last = odd_q && (left_q == COUNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      left_q   <= '0;
      odd_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            left_q   <= pair_count;
            settle_q <= '0;
            odd_q    <= 1'b0;
            if (pair_count == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_q  <= CAPTURE;
          else                                        settle_q <= settle_q + SET_W'(1);
        end
        CAPTURE: begin
          odd_q <= ~odd_q;
          if (odd_q) begin
            if (left_q == COUNT_W'(1)) state_q <= DRAIN;
            else                       left_q  <= left_q - COUNT_W'(1);
          end
        end
        DRAIN: begin
          // Only the tlast word can be pending here.
          if (m_tvalid && m_tready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  syzygy_adc_pack u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_ovf_i(start_ok),
    .cap_vld_i  (cap_vld),
    .cap_odd_i  (odd_q),
    .cap_last_i (cap_last),
    .sample_i   (sample),
    .m_tready_i (m_tready),
    .m_tdata_o  (m_tdata),
    .m_tvalid_o (m_tvalid),
    .m_tlast_o  (m_tlast),
    .overflow_o (overflow)
  );

endmodule

// File: tb/tb_syzygy_adc_capture.sv
// Purpose : randomized and directed bench for syzygy_adc_capture with a
//           cycle-level reference model built from the block's rules.
module tb_syzygy_adc_capture;

  localparam int DW = 12;
  localparam int SC = 8;
  localparam int CW = 16;
  localparam int HN = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, m_tready;
  logic [DW-1:0] adc_data;
  logic [CW-1:0] pair_count;
  logic          busy, done, overflow, m_tvalid, m_tlast;
  logic [31:0]   m_tdata;
`ifdef SYZYGY_ADC_TEST_PATTERN_EN
  logic          test_mode;
`endif

  syzygy_adc_capture #(.DATA_W(DW), .SETTLE_CYCLES(SC), .COUNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_data  (adc_data),
`ifdef SYZYGY_ADC_TEST_PATTERN_EN
    .test_mode (test_mode),
`endif
    .start     (start),
    .pair_count(pair_count),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [DW-1:0] hist [0:HN-1];

  // reference model state
  logic        mb, md, mo, mv, ml, act;
  logic [31:0] mdat;
  int          s_cyc, n_pairs, made;

  // monitors / stimulus controls
  int          acc_cnt, last_cnt, done_cnt;
  logic        busy_seen;
  logic [31:0] got_q [$];
  int          adc_mode;   // 0 random, 1 ramp, 2 held by caller
  logic [DW-1:0] ramp_val;
  logic        rnd_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Signed value = code - midscale, expressed in 16 bits.
  function automatic logic [15:0] conv(input logic [DW-1:0] r);
    int v;
    v = int'(r) - (1 << (DW - 1));
    return 16'(v);
  endfunction

  // Sample k of the running acquisition is the ADC value driven SC+k
  // cycles after the start cycle (one register stage in front of capture).
  function automatic logic [DW-1:0] samp(input int k);
`ifdef SYZYGY_ADC_TEST_PATTERN_EN
    if (test_mode) return DW'(k);
`endif
    return hist[(s_cyc + SC + k) % HN];
  endfunction

  // Advance the model across the clock edge that ends cycle c.
  task automatic model_edge(input int c);
    logic        wr, wl, acc, ob;
    logic [31:0] w;
    wr = 1'b0; wl = 1'b0; w = '0;
    if (!rst_n) begin
      mb = 0; md = 0; mo = 0; mv = 0; ml = 0; mdat = '0; act = 0;
    end else begin
      ob  = mb;
      acc = mv && m_tready;
      md  = 1'b0;
      // Word j completes when its odd sample is captured, 2 cycles apart.
      if (act && made < n_pairs && c == s_cyc + SC + 2 + 2 * made) begin
        w    = {conv(samp(2 * made + 1)), conv(samp(2 * made))};
        wl   = (made == n_pairs - 1);
        made = made + 1;
        wr   = 1'b1;
      end
      if (acc && ml) begin
        mb = 0; md = 1; act = 0;
      end
      if (wr) begin
        if (mv && !m_tready) begin
          mo = 1'b1;
          if (wl) ml = 1'b1;
        end else begin
          mdat = w; mv = 1'b1; ml = wl;
        end
      end else if (acc) begin
        mv = 1'b0; ml = 1'b0;
      end
      if (start && !ob) begin
        mo = 1'b0;
        if (pair_count == '0) md = 1'b1;
        else begin
          mb = 1; act = 1; s_cyc = c; n_pairs = int'(pair_count); made = 0;
        end
      end
    end
  endtask

  task automatic step();
    if (adc_mode == 1) begin
      adc_data = ramp_val;
      ramp_val = ramp_val + 1'b1;
    end else if (adc_mode == 0) begin
      adc_data = DW'($urandom);
    end
    if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
    hist[cyc % HN] = adc_data;
    if (m_tvalid && m_tready) begin
      acc_cnt++;
      got_q.push_back(m_tdata);
      if (m_tlast) last_cnt++;
    end
    @(posedge clk);
    model_edge(cyc);
    cyc++;
    #1;
    chk("busy",     busy,     mb);
    chk("done",     done,     md);
    chk("overflow", overflow, mo);
    chk("tvalid",   m_tvalid, mv);
    chk("tlast",    m_tlast,  ml);
    chk("tdata",    m_tdata,  mdat);
    if (done) done_cnt++;
    if (busy) busy_seen = 1'b1;
  endtask

  task automatic clr_cnt();
    acc_cnt = 0; last_cnt = 0; done_cnt = 0; busy_seen = 0;
    got_q.delete();
  endtask

  task automatic pulse_start(input int n);
    pair_count = CW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin step(); n++; end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!m_tvalid && n < 100) begin step(); n++; end
    chk("vld_timeout", {31'b0, m_tvalid}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    logic [31:0] hold;
    rst_n = 0; start = 0; m_tready = 1; pair_count = '0; adc_data = '0;
    adc_mode = 0; ramp_val = '0; rnd_ready = 0;
`ifdef SYZYGY_ADC_TEST_PATTERN_EN
    test_mode = 0;
`endif
    mb = 0; md = 0; mo = 0; mv = 0; ml = 0; mdat = '0; act = 0;
    s_cyc = 0; n_pairs = 0; made = 0;
    clr_cnt();

    // reset state
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    rst_n = 1;
    repeat (2) step();

    // basic capture: ramp reaches 0x800 on the first captured cycle
    clr_cnt();
    adc_mode = 1;
    ramp_val = DW'(12'h800 - SC);
    s = cyc;
    pulse_start(4);
    wait_vld();
    chk("latency", 32'(cyc - s), 32'd11);
    chk("first_word", m_tdata, 32'h0001_0000);
    wait_idle();
    chk("basic_words", 32'(acc_cnt), 32'd4);
    chk("basic_tlast", 32'(last_cnt), 32'd1);
    chk("basic_done", 32'(done_cnt), 32'd1);

    // zero count
    clr_cnt();
    adc_mode = 0;
    pulse_start(0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    repeat (10) step();
    chk("zero_words", 32'(acc_cnt), 32'd0);
    chk("zero_busy_seen", busy_seen, 0);
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);

    // backpressure: stall 4 cycles from first tvalid
    clr_cnt();
    pulse_start(3);
    wait_vld();
    hold = m_tdata;
    m_tready = 0;
    repeat (4) begin
      step();
      chk("bp_hold_data", m_tdata, hold);
      chk("bp_hold_vld", m_tvalid, 1);
    end
    chk("bp_ovf", overflow, 1);
    chk("bp_forced_tlast", m_tlast, 1);
    m_tready = 1;
    wait_idle();
    chk("bp_words", 32'(acc_cnt), 32'd1);
    chk("bp_tlast", 32'(last_cnt), 32'd1);
    chk("bp_ovf_sticky", overflow, 1);
    step();
    pulse_start(1);
    chk("bp_ovf_clear", overflow, 0);
    wait_idle();

    // extremes: full scale then zero scale
    clr_cnt();
    adc_mode = 2;
    pair_count = CW'(1);
    for (int i = 0; i < SC + 2; i++) begin
      adc_data = (i == SC) ? DW'(12'hFFF) : (i == SC + 1) ? DW'(12'h000) : DW'(12'h5A5);
      start = (i == 0);
      step();
    end
    start = 0;
    wait_idle();
    chk("extreme_word", got_q.size() > 0 ? got_q[0] : 32'hxxxx_xxxx, 32'hF800_07FF);
    adc_mode = 0;

    // reset in the middle of CAPTURE
    clr_cnt();
    pulse_start(5);
    repeat (12) step();
    chk("mid_busy_before", busy, 1);
    rst_n = 0;
    step();
    chk("mid_busy", busy, 0);
    chk("mid_tvalid", m_tvalid, 0);
    chk("mid_done", done, 0);
    rst_n = 1;
    step();
    chk("mid_no_done", done, 0);
    clr_cnt();
    pulse_start(2);
    wait_idle();
    chk("mid_restart_words", 32'(acc_cnt), 32'd2);
    chk("mid_restart_done", 32'(done_cnt), 32'd1);

    // start while busy is ignored
    clr_cnt();
    pulse_start(4);
    repeat (5) step();
    pulse_start(1);
    wait_idle();
    chk("ign_words", 32'(acc_cnt), 32'd4);
    chk("ign_ovf", overflow, 0);
    chk("ign_done", 32'(done_cnt), 32'd1);

    // randomized acquisitions with random backpressure
    rnd_ready = 1;
    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(0, 3)) step();
      pulse_start($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 8)) step();
        pulse_start($urandom_range(0, 5));
      end
      wait_idle();
    end
    rnd_ready = 0;
    m_tready = 1;
    repeat (2) step();

`ifdef SYZYGY_ADC_TEST_PATTERN_EN
    clr_cnt();
    test_mode = 1;
    pulse_start(2);
    wait_idle();
    chk("tp_word0", got_q.size() > 0 ? got_q[0] : 32'hxxxx_xxxx, 32'hF801_F800);
    chk("tp_word1", got_q.size() > 1 ? got_q[1] : 32'hxxxx_xxxx, 32'hF803_F802);
    test_mode = 0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
